// File: rtl/gh_uart_rx_fifo_ctrl_if.sv
// Signal bundle between the RX FIFO read port, the host register file and the RX FIFO controller.
interface gh_uart_rx_fifo_ctrl_if;
  logic        fifo_en;
  logic        fifo_clr;
  logic [1:0]  trig_lvl;
  logic [10:0] f_q;
  logic        f_empty;
  logic        f_q_full;
  logic        f_h_full;
  logic        f_a_full;
  logic        f_full;
  logic        f_wr_req;
  logic        char_tick;
  logic        rd_rbr;
  logic        rd_lsr;
  logic        f_rd;
  logic        f_srst;
  logic [7:0]  rbr;
  logic [2:0]  rbr_err;
  logic        dr;
  logic        oe;
  logic        int_rda;
  logic        int_to;

  modport master (
    output fifo_en, fifo_clr, trig_lvl, f_q, f_empty, f_q_full, f_h_full, f_a_full, f_full,
           f_wr_req, char_tick, rd_rbr, rd_lsr,
    input  f_rd, f_srst, rbr, rbr_err, dr, oe, int_rda, int_to
  );

  modport slave (
    input  fifo_en, fifo_clr, trig_lvl, f_q, f_empty, f_q_full, f_h_full, f_a_full, f_full,
           f_wr_req, char_tick, rd_rbr, rd_lsr,
    output f_rd, f_srst, rbr, rbr_err, dr, oe, int_rda, int_to
  );
endinterface

// File: rtl/gh_uart_rx_fifo_ctrl.sv
// UART RX FIFO read sequencer: prefetches the head word into RBR, tracks overrun, raises RDA/timeout IRQs.
// Character-timeout counter and int_to are built only when GH_UART_RX_TIMEOUT_EN is defined.
module gh_uart_rx_fifo_ctrl (
  input  logic                  clk,
  input  logic                  rst_n,
  gh_uart_rx_fifo_ctrl_if.slave bus
);
  // state    | meaning
  // S_IDLE   | waiting for a word in the FIFO while RBR is free
  // S_FETCH  | f_rd pulse; RBR loads the head word on exit
  // S_SETTLE | one cycle for f_empty to catch up with the read
  // S_CLR    | 3-cycle FIFO clear; f_srst in the first cycle only
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SETTLE, S_CLR} state_t;

  state_t     state_q, state_d;
  logic [1:0] clr_cnt_q, clr_cnt_d;
  logic [7:0] rbr_q, rbr_d;
  logic [2:0] rbr_err_q, rbr_err_d;
  logic       dr_q, dr_d;
  logic       oe_q, oe_d;
  logic       level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      clr_cnt_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (bus.fifo_clr) begin
      state_d   = S_CLR;
      clr_cnt_d = 2'd0;
    end else begin
      case (state_q)
        S_IDLE:   if (!bus.f_empty && !dr_q) state_d = S_FETCH;
        S_FETCH:  state_d = S_SETTLE;
        S_SETTLE: state_d = S_IDLE;
        S_CLR: begin
          clr_cnt_d = clr_cnt_q + 2'd1;
          if (clr_cnt_q == 2'd2) begin
            state_d   = S_IDLE;
            clr_cnt_d = 2'd0;
          end
        end
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.f_rd   = (state_q == S_FETCH);
    bus.f_srst = (state_q == S_CLR) && (clr_cnt_q == 2'd0);
  end

  // f_q[10:8] is {break, framing, parity}, which is already the rbr_err order
  always_comb begin
    rbr_d     = rbr_q;
    rbr_err_d = rbr_err_q;
    dr_d      = dr_q;
    if (bus.fifo_clr) begin
      rbr_d     = 8'd0;
      rbr_err_d = 3'd0;
      dr_d      = 1'b0;
    end else if (state_q == S_FETCH) begin
      rbr_d     = bus.f_q[7:0];
      rbr_err_d = bus.f_q[10:8];
      dr_d      = 1'b1;
    end else if (bus.rd_rbr) begin
      dr_d      = 1'b0;
    end
    oe_d = (bus.f_wr_req && bus.f_full) || (oe_q && !bus.rd_lsr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rbr_q     <= 8'd0;
      rbr_err_q <= 3'd0;
      dr_q      <= 1'b0;
      oe_q      <= 1'b0;
    end else begin
      rbr_q     <= rbr_d;
      rbr_err_q <= rbr_err_d;
      dr_q      <= dr_d;
      oe_q      <= oe_d;
    end
  end

  always_comb begin
    level = 1'b1;
    case (bus.trig_lvl)
      2'b00:   level = 1'b1;
      2'b01:   level = bus.f_q_full;
      2'b10:   level = bus.f_h_full;
      default: level = bus.f_a_full;
    endcase
  end

  assign bus.rbr     = rbr_q;
  assign bus.rbr_err = rbr_err_q;
  assign bus.dr      = dr_q;
  assign bus.oe      = oe_q;
  assign bus.int_rda = dr_q && (bus.fifo_en ? level : 1'b1);

`ifdef GH_UART_RX_TIMEOUT_EN
  logic [2:0] to_cnt_q, to_cnt_d;

  // Saturates at 4 character times so int_to stays up until the host reacts
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (bus.fifo_clr || bus.f_wr_req || bus.rd_rbr || !dr_q) begin
      to_cnt_d = 3'd0;
    end else if (bus.char_tick && (to_cnt_q != 3'd4)) begin
      to_cnt_d = to_cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_cnt_q <= 3'd0;
    else        to_cnt_q <= to_cnt_d;
  end

  assign bus.int_to = (to_cnt_q == 3'd4) && dr_q && bus.fifo_en;
`else
  logic unused_char_tick;
  assign unused_char_tick = bus.char_tick;
  assign bus.int_to       = 1'b0;
`endif
endmodule

// File: tb/tb_gh_uart_rx_fifo_ctrl.sv
// Bench for gh_uart_rx_fifo_ctrl: behavioural RX FIFO plus a word scoreboard, directed steps with random data.
module tb_gh_uart_rx_fifo_ctrl;
`ifdef GH_UART_RX_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic [10:0] wr_data;
  logic [10:0] fq[$];
  logic [10:0] sb[$];
  int n_cmp, n_mis;
  int rd_cnt, b2b_cnt, bad_rd, old_sz, new_sz;
  logic rd_prev;

  gh_uart_rx_fifo_ctrl_if u_if();

  gh_uart_rx_fifo_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 16-deep FIFO: empty lags the occupancy by one cycle, other flags track it
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      u_if.f_q      <= 11'd0;
      u_if.f_empty  <= 1'b1;
      u_if.f_q_full <= 1'b0;
      u_if.f_h_full <= 1'b0;
      u_if.f_a_full <= 1'b0;
      u_if.f_full   <= 1'b0;
    end else begin
      old_sz = fq.size();
      if (u_if.f_rd) begin
        if (old_sz > 0) void'(fq.pop_front());
        else bad_rd++;
      end
      if (u_if.f_wr_req && old_sz < 16) fq.push_back(wr_data);
      if (u_if.f_srst) fq.delete();
      new_sz = fq.size();
      u_if.f_empty  <= (old_sz == 0);
      u_if.f_q_full <= (new_sz >= 4);
      u_if.f_h_full <= (new_sz >= 8);
      u_if.f_a_full <= (new_sz >= 14);
      u_if.f_full   <= (new_sz >= 16);
      u_if.f_q      <= (new_sz > 0) ? fq[0] : 11'd0;
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (u_if.f_rd) rd_cnt++;
      if (u_if.f_rd && rd_prev) b2b_cnt++;
      rd_prev = u_if.f_rd;
    end else begin
      rd_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [10:0] w);
    logic acc;
    acc = !u_if.f_full;
    wr_data = w;
    u_if.f_wr_req = 1'b1;
    tick();
    u_if.f_wr_req = 1'b0;
    if (acc) sb.push_back(w);
  endtask

  task automatic push_rnd();
    logic [31:0] r;
    r = $urandom;
    push(r[10:0]);
  endtask

  task automatic pulse_tick();
    u_if.char_tick = 1'b1;
    tick();
    u_if.char_tick = 1'b0;
  endtask

  task automatic wait_dr(input int max);
    int n;
    n = 0;
    while (!u_if.dr && n < max) begin
      tick();
      n++;
    end
    chk("wait_dr", u_if.dr, 1);
  endtask

  // Host read: checks RBR against the scoreboard and, when another word is queued,
  // the 3-edge turnaround to the next dr
  task automatic read_word();
    logic [10:0] w;
    wait_dr(20);
    chk("sb_has_word", sb.size() > 0, 1);
    w = (sb.size() > 0) ? sb.pop_front() : 11'd0;
    repeat ($urandom_range(0, 3)) tick();
    chk("rbr", u_if.rbr, w[7:0]);
    chk("rbr_err", u_if.rbr_err, w[10:8]);
    u_if.rd_rbr = 1'b1;
    tick();
    u_if.rd_rbr = 1'b0;
    chk("dr_after_read", u_if.dr, 0);
    if (sb.size() > 0) begin
      tick();
      chk("dr_edge2", u_if.dr, 0);
      tick();
      chk("dr_edge3", u_if.dr, 1);
    end
  endtask

  function automatic logic lvl_exp(input int t, input int words);
    case (t)
      0:       return 1'b1;
      1:       return words >= 4;
      2:       return words >= 8;
      default: return words >= 14;
    endcase
  endfunction

  initial begin
    int rd0, n;
    n_cmp = 0; n_mis = 0; rd_cnt = 0; b2b_cnt = 0; bad_rd = 0; rd_prev = 1'b0;
    wr_data = 11'd0;
    rst_n = 1'b0;
    u_if.fifo_en = 1'b1; u_if.fifo_clr = 1'b0; u_if.trig_lvl = 2'b00;
    u_if.f_wr_req = 1'b0; u_if.char_tick = 1'b0; u_if.rd_rbr = 1'b0; u_if.rd_lsr = 1'b0;
    repeat (3) tick();
    chk("rst_f_rd", u_if.f_rd, 0);
    chk("rst_f_srst", u_if.f_srst, 0);
    chk("rst_rbr", u_if.rbr, 0);
    chk("rst_rbr_err", u_if.rbr_err, 0);
    chk("rst_dr", u_if.dr, 0);
    chk("rst_oe", u_if.oe, 0);
    chk("rst_int_rda", u_if.int_rda, 0);
    chk("rst_int_to", u_if.int_to, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // first word: two edges from f_empty falling to dr
    rd0 = rd_cnt;
    push(11'h0A5);
    n = 0;
    while (u_if.f_empty && n < 8) begin tick(); n++; end
    chk("empty_fall", u_if.f_empty, 0);
    tick();
    chk("dr_lat1", u_if.dr, 0);
    tick();
    chk("dr_lat2", u_if.dr, 1);
    chk("rbr_a5", u_if.rbr, 8'hA5);
    chk("rbr_err_a5", u_if.rbr_err, 3'b000);
    chk("int_rda_lvl1", u_if.int_rda, 1);
    repeat (3) tick();
    chk("f_rd_once", rd_cnt - rd0, 1);
    read_word();

    // random burst
    repeat (6) push_rnd();
    repeat (6) read_word();

    // trigger levels against FIFO occupancy
    u_if.trig_lvl = 2'b10;
    repeat (9) push_rnd();
    wait_dr(20);
    repeat (4) tick();
    for (int t = 0; t < 4; t++) begin
      u_if.trig_lvl = 2'(t);
      #1;
      chk("int_rda_9w", u_if.int_rda, lvl_exp(t, sb.size() - 1));
    end
    u_if.trig_lvl = 2'b10;
    read_word();
    for (int t = 0; t < 4; t++) begin
      u_if.trig_lvl = 2'(t);
      #1;
      chk("int_rda_8w", u_if.int_rda, lvl_exp(t, sb.size() - 1));
    end
    chk("dr_8w", u_if.dr, 1);
    u_if.trig_lvl = 2'b00;
    while (sb.size() > 0) read_word();

    // character timeout
    push_rnd();
    wait_dr(20);
    tick();
    repeat (3) pulse_tick();
    chk("int_to_3", u_if.int_to, 0);
    pulse_tick();
    chk("int_to_4", u_if.int_to, TO_EN);
    pulse_tick();
    chk("int_to_sat", u_if.int_to, TO_EN);
    read_word();
    chk("int_to_rd", u_if.int_to, 0);

    // overrun
    chk("oe_pre", u_if.oe, 0);
    repeat (17) push_rnd();
    repeat (4) tick();
    push_rnd();
    chk("oe_set", u_if.oe, 1);
    u_if.rd_lsr = 1'b1;
    tick();
    u_if.rd_lsr = 1'b0;
    chk("oe_lsr_clr", u_if.oe, 0);
    u_if.rd_lsr = 1'b1;
    push_rnd();
    u_if.rd_lsr = 1'b0;
    chk("oe_set_wins", u_if.oe, 1);
    read_word();
    chk("oe_sticky_rbr", u_if.oe, 1);
    u_if.rd_lsr = 1'b1;
    tick();
    u_if.rd_lsr = 1'b0;
    chk("oe_clr2", u_if.oe, 0);
    while (sb.size() > 0) read_word();

    // fifo_clr during FETCH
    push_rnd();
    n = 0;
    while (!u_if.f_rd && n < 10) begin tick(); n++; end
    chk("fetch_seen", u_if.f_rd, 1);
    u_if.fifo_clr = 1'b1;
    tick();
    u_if.fifo_clr = 1'b0;
    sb.delete();
    chk("clr_srst0", u_if.f_srst, 1);
    chk("clr_dr", u_if.dr, 0);
    chk("clr_rbr", u_if.rbr, 0);
    chk("clr_rbr_err", u_if.rbr_err, 0);
    chk("clr_f_rd0", u_if.f_rd, 0);
    tick();
    chk("clr_srst1", u_if.f_srst, 0);
    chk("clr_f_rd1", u_if.f_rd, 0);
    tick();
    chk("clr_srst2", u_if.f_srst, 0);
    chk("clr_f_rd2", u_if.f_rd, 0);
    tick();
    push_rnd();
    read_word();

    // FIFO disabled: int_rda follows dr, no timeout
    u_if.fifo_en = 1'b0;
    u_if.trig_lvl = 2'b11;
    push(11'h4C3);
    wait_dr(20);
    chk("nf_int_rda", u_if.int_rda, 1);
    chk("nf_rbr", u_if.rbr, 8'hC3);
    chk("nf_rbr_err", u_if.rbr_err, 3'b100);
    repeat (10) pulse_tick();
    chk("nf_int_to", u_if.int_to, 0);
    chk("nf_int_rda2", u_if.int_rda, 1);
    read_word();
    u_if.fifo_en = 1'b1;
    u_if.trig_lvl = 2'b00;

    // reset in the middle of FETCH
    push_rnd();
    n = 0;
    while (!u_if.f_rd && n < 10) begin tick(); n++; end
    chk("rst_fetch_seen", u_if.f_rd, 1);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("arst_f_rd", u_if.f_rd, 0);
    chk("arst_dr", u_if.dr, 0);
    chk("arst_rbr", u_if.rbr, 0);
    chk("arst_int_rda", u_if.int_rda, 0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    chk("f_rd_back_to_back", b2b_cnt, 0);
    chk("f_rd_when_empty", bad_rd, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
